// File: rtl/cpu_pkg.sv
// Shared load/store size codes, mem_access FSM states and request legality check.
package cpu_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    WB,
    ERR
  } state_t;

  // Unsigned sizes only make sense for loads, so a store with BU/HU is rejected.
  function automatic logic req_illegal(input logic ld, input logic st,
                                       input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = (ld == st);
    case (f3)
      LS_B:    bad = bad;
      LS_H:    bad = bad | a[0];
      LS_W:    bad = bad | (a != 2'b00);
      LS_BU:   bad = bad | st;
      LS_HU:   bad = bad | st | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store lane/enable generation and load byte/halfword extract with extension.
module lsu_align
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wren,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{byte_off, 3'b000} +: 8];
  assign half_v = byte_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    wren  = 4'b0000;
    wdata = store_data;
    // Store lanes: funct3[1:0] carries the size since unsigned stores are already rejected.
    case (funct3[1:0])
      2'b00: begin
        wren  = 4'b0001 << byte_off;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wren  = 4'b0011 << byte_off;
        wdata = {2{store_data[15:0]}};
      end
      2'b10:   wren = 4'b1111;
      default: wren = 4'b0000;
    endcase
  end

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      LS_B:    load_data = {{24{byte_v[7]}}, byte_v};
      LS_H:    load_data = {{16{half_v[15]}}, half_v};
      LS_W:    load_data = rdata;
      LS_BU:   load_data = {24'h0, byte_v};
      LS_HU:   load_data = {16'h0, half_v};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Load/store stage: one operation at a time, request/grant to data memory, load writeback.
module mem_access
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [4:0]        rd,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wren,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              done,
  output logic              err
);

  state_t            state_reg, state_next;
  logic              done_reg, done_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [2:0]        funct3_reg;
  logic [4:0]        rd_reg;
  logic              is_load_reg;
  logic [3:0]        wren_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       wb_data_reg;

  logic              illegal;
  logic [2:0]        f3_sel;
  logic [1:0]        off_sel;
  logic [3:0]        align_wren;
  logic [31:0]       align_wdata;
  logic [31:0]       align_load;

  assign illegal = req_illegal(is_load, is_store, funct3, addr[1:0]);

  // One aligner serves both paths: live inputs while idle (store capture), captured ones after.
  assign f3_sel  = (state_reg == IDLE) ? funct3    : funct3_reg;
  assign off_sel = (state_reg == IDLE) ? addr[1:0] : addr_reg[1:0];

  lsu_align u_align (
    .funct3    (f3_sel),
    .byte_off  (off_sel),
    .store_data(store_data),
    .rdata     (mem_rdata),
    .wren      (align_wren),
    .wdata     (align_wdata),
    .load_data (align_load)
  );

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: if (req_valid) begin
        state_next = illegal ? ERR : REQ;
        done_next  = illegal;
      end
      REQ: if (mem_gnt) begin
        if (is_load_reg) begin
          state_next = RESP;
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      RESP: if (mem_rvalid) begin
        state_next = WB;
        done_next  = 1'b1;
      end
      WB:      state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      addr_reg    <= '0;
      funct3_reg  <= 3'b000;
      rd_reg      <= 5'd0;
      is_load_reg <= 1'b0;
      wren_reg    <= 4'b0000;
      wdata_reg   <= 32'h0;
      wb_data_reg <= 32'h0;
    end else begin
      if (state_reg == IDLE && req_valid) begin
        addr_reg    <= addr;
        funct3_reg  <= funct3;
        rd_reg      <= rd;
        is_load_reg <= is_load;
        wren_reg    <= (is_store && !illegal) ? align_wren : 4'b0000;
        wdata_reg   <= align_wdata;
      end
      if (state_reg == RESP && mem_rvalid) begin
        wb_data_reg <= align_load;
      end
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign mem_req   = (state_reg == REQ);
  assign wb_valid  = (state_reg == WB);
  assign err       = (state_reg == ERR);
  assign done      = done_reg;
  assign mem_addr  = {addr_reg[ADDR_W-1:2], 2'b00};
  assign mem_wren  = wren_reg;
  assign mem_wdata = wdata_reg;
  assign wb_rd     = rd_reg;
  assign wb_data   = wb_data_reg;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access: stores, loads, errors and reset mid-load.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rstd;
  logic        req_valid, req_ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [4:0]  rd, wb_rd;
  logic        mem_req, mem_gnt, mem_rvalid, wb_valid, done, err;
  logic [3:0]  mem_wren;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rstd(rstd), .req_valid(req_valid), .req_ready(req_ready),
    .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .rd(rd), .mem_req(mem_req), .mem_gnt(mem_gnt),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = sd; rd = r;
    step();
    req_valid = 1'b0;
  endtask

  // Accept, grant immediately, return rdata on the next cycle, then check the writeback.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] r, input logic [31:0] rdata, input logic [31:0] exp);
    offer(1'b1, 1'b0, f3, a, 32'h0, r);
    chk({tag, "_req"}, {31'h0, mem_req}, 32'd1);
    chk({tag, "_addr"}, mem_addr, a & 32'hFFFF_FFFC);
    chk({tag, "_wren"}, {28'h0, mem_wren}, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk({tag, "_resp_req"}, {31'h0, mem_req}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0;
    chk({tag, "_wbv"}, {31'h0, wb_valid}, 32'd1);
    chk({tag, "_done"}, {31'h0, done}, 32'd1);
    chk({tag, "_rd"}, {27'h0, wb_rd}, {27'h0, r});
    chk({tag, "_data"}, wb_data, exp);
    step();
    chk({tag, "_wbv_end"}, {31'h0, wb_valid}, 32'd0);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
    $display("load %s addr=%h rdata=%h wb_data=%h", tag, a, rdata, wb_data);
  endtask

  task automatic run_err(input string tag, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a);
    offer(ld, st, f3, a, 32'h0, 5'd1);
    chk({tag, "_err"}, {31'h0, err}, 32'd1);
    chk({tag, "_done"}, {31'h0, done}, 32'd1);
    chk({tag, "_req"}, {31'h0, mem_req}, 32'd0);
    chk({tag, "_busy"}, {31'h0, req_ready}, 32'd0);
    step();
    chk({tag, "_err_end"}, {31'h0, err}, 32'd0);
    chk({tag, "_req2"}, {31'h0, mem_req}, 32'd0);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
    $display("error %s addr=%h funct3=%b", tag, a, f3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rstd = 1'b0; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; rd = 5'd0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #12;
    chk("rst_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_req", {31'h0, mem_req}, 32'd0);
    chk("rst_wbv", {31'h0, wb_valid}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_wren", {28'h0, mem_wren}, 32'h0);
    $display("reset checked");
    rstd = 1'b1;
    step();

    // SW with grant held off for three cycles.
    offer(1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
    for (int i = 0; i < 4; i++) begin
      chk("sw_req", {31'h0, mem_req}, 32'd1);
      chk("sw_addr", mem_addr, 32'h0000_0010);
      chk("sw_wren", {28'h0, mem_wren}, 32'hF);
      chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("sw_done_early", {31'h0, done}, 32'd0);
      if (i == 3) mem_gnt = 1'b1;
      step();
    end
    mem_gnt = 1'b0;
    chk("sw_done", {31'h0, done}, 32'd1);
    chk("sw_ready", {31'h0, req_ready}, 32'd1);
    chk("sw_req_end", {31'h0, mem_req}, 32'd0);
    $display("store SW addr=10 wdata=%h done=%b", mem_wdata, done);
    step();
    chk("sw_done_end", {31'h0, done}, 32'd0);

    // SB at byte 3, grant asserted early (ignored while idle).
    mem_gnt = 1'b1;
    offer(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 5'd0);
    chk("sb_req", {31'h0, mem_req}, 32'd1);
    chk("sb_addr", mem_addr, 32'h0000_0010);
    chk("sb_wren", {28'h0, mem_wren}, 32'h8);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    step();
    mem_gnt = 1'b0;
    chk("sb_done", {31'h0, done}, 32'd1);
    $display("store SB addr=13 wren=%b wdata=%h", mem_wren, mem_wdata);
    step();

    // SH to upper half.
    offer(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h1234_BEEF, 5'd0);
    chk("sh_wren", {28'h0, mem_wren}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("sh_done", {31'h0, done}, 32'd1);
    $display("store SH addr=12 wren=%b wdata=%h", mem_wren, mem_wdata);
    step();

    run_load("lb",  3'b000, 32'h0000_0021, 5'd7,  32'h1234_80FF, 32'hFFFF_FF80);
    run_load("lbu", 3'b100, 32'h0000_0021, 5'd9,  32'h1234_80FF, 32'h0000_0080);
    run_load("lb3", 3'b000, 32'h0000_0023, 5'd3,  32'h7F00_0000, 32'h0000_007F);
    run_load("lh",  3'b001, 32'h0000_0022, 5'd12, 32'h8001_0000, 32'hFFFF_8001);
    run_load("lhu", 3'b101, 32'h0000_0022, 5'd31, 32'h8001_0000, 32'h0000_8001);
    run_load("lw",  3'b010, 32'h0000_0024, 5'd0,  32'hCAFE_F00D, 32'hCAFE_F00D);

    run_err("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0006);
    run_err("lh_mis", 1'b1, 1'b0, 3'b001, 32'h0000_0003);
    run_err("both",   1'b1, 1'b1, 3'b000, 32'h0000_0000);
    run_err("f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0000);
    run_err("sbu",    1'b0, 1'b1, 3'b100, 32'h0000_0000);

    // Reset while waiting in RESP; a late rvalid must not produce a writeback.
    offer(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd5);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #2;
    rstd = 1'b0;
    #1;
    chk("rstm_req", {31'h0, mem_req}, 32'd0);
    chk("rstm_wbv", {31'h0, wb_valid}, 32'd0);
    chk("rstm_ready", {31'h0, req_ready}, 32'd1);
    #3;
    rstd = 1'b1;
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_rvalid = 1'b0;
    chk("rstm_late_wbv", {31'h0, wb_valid}, 32'd0);
    chk("rstm_late_done", {31'h0, done}, 32'd0);
    chk("rstm_late_ready", {31'h0, req_ready}, 32'd1);
    $display("reset mid-load wb_valid=%b req_ready=%b", wb_valid, req_ready);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
